// File: rtl/lsu_byte_seq_if.sv
// Request/response and byte-memory bus for the byte-serial load/store sequencer.
// The slave modport is the sequencer's view of the bus. The master modport is the requester/memory side.
interface lsu_byte_seq_if #(
   parameter int addr_size   = 64,
   parameter int data_length = 64
);
   logic                   req_valid;
   logic                   req_ready;
   logic                   req_write;
   logic [2:0]             req_funct3;
   logic [addr_size-1:0]   req_addr;
   logic [data_length-1:0] req_wdata;
   logic                   resp_valid;
   logic [data_length-1:0] resp_rdata;
   logic                   resp_err;
   logic                   mem_read;
   logic                   mem_write;
   logic [addr_size-1:0]   mem_addr;
   logic [7:0]             mem_wdata;
   logic [7:0]             mem_rdata;

   modport slave (
      input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output mem_read, mem_write, mem_addr, mem_wdata
   );

   modport master (
      output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  mem_read, mem_write, mem_addr, mem_wdata
   );
endinterface

// File: rtl/lsu_byte_seq.sv
// Byte-serial RV64 load/store sequencer: splits B/H/W/D accesses into single-byte memory cycles.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned requests respond at once with resp_err instead of executing.
module lsu_byte_seq #(
   parameter int addr_size   = 64,
   parameter int data_length = 64
) (
   input logic           clk,
   input logic           rst,
   lsu_byte_seq_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t                 state_q, state_d;
   logic [addr_size-1:0]   base_q, base_d;
   logic [63:0]            wdata_q, wdata_d;
   logic                   write_q, write_d;
   logic                   zext_q, zext_d;
   logic [2:0]             nlast_q, nlast_d;
   logic [2:0]             k_q, k_d;
   logic [63:0]            asm_q, asm_d;
   logic [data_length-1:0] rdata_q, rdata_d;
   logic [2:0]             req_nlast;

`ifdef LSU_MISALIGN_TRAP_EN
   logic err_q, err_d;
   logic misaligned;
`endif

   // Assembled bytes 0..nlast kept as-is; every byte above them becomes sign or zero fill.
   function automatic logic [data_length-1:0] extend_bytes(input logic [63:0] v,
                                                           input logic [2:0] nlast,
                                                           input logic zext);
      logic                   fill;
      logic [data_length-1:0] res;
      case (nlast)
         3'd0:    fill = v[7];
         3'd1:    fill = v[15];
         3'd3:    fill = v[31];
         default: fill = v[63];
      endcase
      fill = fill & ~zext;
      res  = {data_length{fill}};
      for (int i = 0; i < 8; i++) begin
         if (3'(i) <= nlast) begin
            res[8*i +: 8] = v[8*i +: 8];
         end
      end
      return res;
   endfunction

   always_comb begin
      case (bus.req_funct3[1:0])
         2'b00:   req_nlast = 3'd0;
         2'b01:   req_nlast = 3'd1;
         2'b10:   req_nlast = 3'd3;
         default: req_nlast = 3'd7;
      endcase
   end

`ifdef LSU_MISALIGN_TRAP_EN
   assign misaligned = (bus.req_addr[2:0] & req_nlast) != 3'b000;
`endif

   always_comb begin
      state_d        = state_q;
      base_d         = base_q;
      wdata_d        = wdata_q;
      write_d        = write_q;
      zext_d         = zext_q;
      nlast_d        = nlast_q;
      k_d            = k_q;
      asm_d          = asm_q;
      rdata_d        = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
      err_d          = err_q;
`endif
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.mem_wdata  = 8'h00;
      bus.mem_addr   = base_q + addr_size'(k_q);

      case (state_q)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               base_d  = bus.req_addr;
               wdata_d = bus.req_wdata[63:0];
               write_d = bus.req_write;
               zext_d  = bus.req_funct3[2] && (bus.req_funct3[1:0] != 2'b11) && !bus.req_write;
               nlast_d = req_nlast;
               k_d     = 3'd0;
               asm_d   = 64'd0;
               state_d = ACCESS;
`ifdef LSU_MISALIGN_TRAP_EN
               err_d = 1'b0;
               if (misaligned) begin
                  err_d   = 1'b1;
                  rdata_d = '0;
                  state_d = RESP;
               end
`endif
            end
         end
         ACCESS: begin
            bus.mem_read  = !write_q;
            bus.mem_write = write_q;
            if (write_q) begin
               bus.mem_wdata = wdata_q[{k_q, 3'b000} +: 8];
            end else begin
               asm_d[{k_q, 3'b000} +: 8] = bus.mem_rdata;
            end
            k_d = k_q + 3'd1;
            // The result register is loaded only here, so it holds between responses.
            if (k_q == nlast_q) begin
               state_d = RESP;
               rdata_d = write_q ? '0 : extend_bytes(asm_d, nlast_q, zext_q);
            end
         end
         RESP: begin
            bus.resp_valid = 1'b1;
            state_d        = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.resp_rdata = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
   assign bus.resp_err = err_q && (state_q == RESP);
`else
   assign bus.resp_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         base_q  <= '0;
         wdata_q <= '0;
         write_q <= 1'b0;
         zext_q  <= 1'b0;
         nlast_q <= 3'd0;
         k_q     <= 3'd0;
         asm_q   <= '0;
         rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         wdata_q <= wdata_d;
         write_q <= write_d;
         zext_q  <= zext_d;
         nlast_q <= nlast_d;
         k_q     <= k_d;
         asm_q   <= asm_d;
         rdata_q <= rdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
         err_q   <= err_d;
`endif
      end
   end
endmodule

// File: tb/tb_lsu_byte_seq.sv
// Self-checking bench for lsu_byte_seq: table of load/store vectors over a 64-byte memory model,
// plus hand-written reset-abort, reset-priority and back-to-back request sequences.
module tb_lsu_byte_seq;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   lsu_byte_seq_if #(.addr_size(64), .data_length(64)) bus ();

   lsu_byte_seq #(.addr_size(64), .data_length(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [7:0]  memArr [64];
   logic [63:0] readAddrLog[$];
   logic [63:0] writeAddrLog[$];
   logic [7:0]  writeDataLog[$];
   int          acceptLog[$];
   int          respLog[$];
   int          overlapCount = 0;
   int          cycleCount = 0;
   int          checks = 0;
   int          failures = 0;

   assign bus.mem_rdata = memArr[bus.mem_addr[5:0]];

   // Byte memory (0xFF everywhere, 0xAA at byte 12) plus a log of every strobe, acceptance and response.
   initial begin
      for (int i = 0; i < 64; i++) memArr[i] = 8'hFF;
      memArr[12] = 8'hAA;
      forever begin
         @(posedge clk);
         if (bus.mem_read && bus.mem_write) overlapCount++;
         if (bus.mem_read) readAddrLog.push_back(bus.mem_addr);
         if (bus.mem_write) begin
            writeAddrLog.push_back(bus.mem_addr);
            writeDataLog.push_back(bus.mem_wdata);
            memArr[bus.mem_addr[5:0]] <= bus.mem_wdata;
         end
         if (!rst && bus.req_valid && bus.req_ready) acceptLog.push_back(cycleCount);
         if (bus.resp_valid) respLog.push_back(cycleCount);
         cycleCount++;
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   typedef struct {
      string       name;
      logic        write;
      logic [2:0]  funct3;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [63:0] expRdata;
      logic        expErr;
      int          expLat;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input string n, input logic w, input logic [2:0] f, input logic [63:0] a,
                               input logic [63:0] wd, input logic [63:0] er, input logic ee, input int el);
      vec_t v;
      v.name = n; v.write = w; v.funct3 = f; v.addr = a; v.wdata = wd;
      v.expRdata = er; v.expErr = ee; v.expLat = el;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%h expected 0x%h", name, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic wr, input logic [2:0] f3, input logic [63:0] addr,
                                input logic [63:0] wdata, output int lat, output logic [63:0] rdata,
                                output logic err, output logic readyAfter);
      int waitCnt;
      @(negedge clk);
      waitCnt = 0;
      while (!bus.req_ready && waitCnt < 20) begin
         @(negedge clk);
         waitCnt++;
      end
      bus.req_valid  = 1'b1;
      bus.req_write  = wr;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      @(posedge clk);
      lat = -1; rdata = '0; err = 1'b0; readyAfter = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 1) bus.req_valid = 1'b0;
         if (bus.resp_valid) begin
            lat   = c;
            rdata = bus.resp_rdata;
            err   = bus.resp_err;
            break;
         end
      end
      bus.req_valid = 1'b0;
      @(negedge clk);
      readyAfter = bus.req_ready;
   endtask

   initial begin
      int          lat, r0, w0, a0, s0, nr, nw, expReads, expWrites;
      logic [63:0] rdata, wd;
      logic        err, readyAfter;

`ifdef LSU_MISALIGN_TRAP_EN
      vecs.push_back(mk("LB 12",      0, 3'b000, 64'd12, 64'd0, 64'hFFFFFFFFFFFFFFAA, 0, 2));
      vecs.push_back(mk("LBU 12",     0, 3'b100, 64'd12, 64'd0, 64'h00000000000000AA, 0, 2));
      vecs.push_back(mk("LW 13",      0, 3'b010, 64'd13, 64'd0, 64'h0, 1, 1));
      vecs.push_back(mk("LW wrap",    0, 3'b010, 64'hFFFFFFFFFFFFFFFE, 64'd0, 64'h0, 1, 1));
`else
      vecs.push_back(mk("LB 12",      0, 3'b000, 64'd12, 64'd0, 64'hFFFFFFFFFFFFFFAA, 0, 2));
      vecs.push_back(mk("LBU 12",     0, 3'b100, 64'd12, 64'd0, 64'h00000000000000AA, 0, 2));
      vecs.push_back(mk("LW 13",      0, 3'b010, 64'd13, 64'd0, 64'hFFFFFFFFFFFFFFFF, 0, 5));
      vecs.push_back(mk("LW wrap",    0, 3'b010, 64'hFFFFFFFFFFFFFFFE, 64'd0, 64'hFFFFFFFFFFFFFFFF, 0, 5));
`endif
      vecs.push_back(mk("SD 16",      1, 3'b011, 64'd16, 64'h0123456789ABCDEF, 64'h0, 0, 9));
      vecs.push_back(mk("LD 16",      0, 3'b011, 64'd16, 64'd0, 64'h0123456789ABCDEF, 0, 9));
      vecs.push_back(mk("LW 16",      0, 3'b010, 64'd16, 64'd0, 64'hFFFFFFFF89ABCDEF, 0, 5));
      vecs.push_back(mk("LHU 20",     0, 3'b101, 64'd20, 64'd0, 64'h0000000000004567, 0, 3));
      vecs.push_back(mk("LH 16",      0, 3'b001, 64'd16, 64'd0, 64'hFFFFFFFFFFFFCDEF, 0, 3));
      vecs.push_back(mk("LWU 16",     0, 3'b110, 64'd16, 64'd0, 64'h0000000089ABCDEF, 0, 5));
      vecs.push_back(mk("f3=111 16",  0, 3'b111, 64'd16, 64'd0, 64'h0123456789ABCDEF, 0, 9));
      vecs.push_back(mk("LB 23",      0, 3'b000, 64'd23, 64'd0, 64'h0000000000000001, 0, 2));
      vecs.push_back(mk("SB(f3=100) 40", 1, 3'b100, 64'd40, 64'hDEADBEEF00000055, 64'h0, 0, 2));
      vecs.push_back(mk("LB 40",      0, 3'b000, 64'd40, 64'd0, 64'h0000000000000055, 0, 2));
      vecs.push_back(mk("LH 40",      0, 3'b001, 64'd40, 64'd0, 64'hFFFFFFFFFFFFFF55, 0, 3));
      vecs.push_back(mk("SH(f3=101) 42", 1, 3'b101, 64'd42, 64'h0000000000008001, 64'h0, 0, 3));
      vecs.push_back(mk("LH 42",      0, 3'b001, 64'd42, 64'd0, 64'hFFFFFFFFFFFF8001, 0, 3));
      vecs.push_back(mk("LHU 42",     0, 3'b101, 64'd42, 64'd0, 64'h0000000000008001, 0, 3));

      rst = 1'b1;
      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'b000;
      bus.req_addr = '0; bus.req_wdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset req_ready",  64'(bus.req_ready), 64'd1);
      checkOutput("reset resp_valid", 64'(bus.resp_valid), 64'd0);
      checkOutput("reset resp_rdata", bus.resp_rdata, 64'd0);
      checkOutput("reset resp_err",   64'(bus.resp_err), 64'd0);
      checkOutput("reset mem_read",   64'(bus.mem_read), 64'd0);
      checkOutput("reset mem_write",  64'(bus.mem_write), 64'd0);
      checkOutput("reset mem_wdata",  64'(bus.mem_wdata), 64'd0);
      rst = 1'b0;

      foreach (vecs[vi]) begin
         r0 = readAddrLog.size();
         w0 = writeAddrLog.size();
         applyStimulus(vecs[vi].write, vecs[vi].funct3, vecs[vi].addr, vecs[vi].wdata,
                       lat, rdata, err, readyAfter);
         checkOutput($sformatf("%s rdata", vecs[vi].name), rdata, vecs[vi].expRdata);
         checkOutput($sformatf("%s err", vecs[vi].name), 64'(err), 64'(vecs[vi].expErr));
         checkOutput($sformatf("%s latency", vecs[vi].name), 64'(lat), 64'(vecs[vi].expLat));
         checkOutput($sformatf("%s ready after", vecs[vi].name), 64'(readyAfter), 64'd1);
         expReads  = (!vecs[vi].write && !vecs[vi].expErr) ? vecs[vi].expLat - 1 : 0;
         expWrites = ( vecs[vi].write && !vecs[vi].expErr) ? vecs[vi].expLat - 1 : 0;
         nr = readAddrLog.size() - r0;
         nw = writeAddrLog.size() - w0;
         checkOutput($sformatf("%s read strobes", vecs[vi].name), 64'(nr), 64'(expReads));
         checkOutput($sformatf("%s write strobes", vecs[vi].name), 64'(nw), 64'(expWrites));
         for (int i = 0; i < nr && i < 8; i++)
            checkOutput($sformatf("%s raddr[%0d]", vecs[vi].name, i), readAddrLog[r0+i],
                        vecs[vi].addr + 64'(i));
         wd = vecs[vi].wdata;
         for (int i = 0; i < nw && i < 8; i++) begin
            checkOutput($sformatf("%s waddr[%0d]", vecs[vi].name, i), writeAddrLog[w0+i],
                        vecs[vi].addr + 64'(i));
            checkOutput($sformatf("%s wbyte[%0d]", vecs[vi].name, i), 64'(writeDataLog[w0+i]),
                        64'(wd[8*i +: 8]));
         end
      end

      // Reset in the same cycle as a valid request must win: no access starts.
      @(negedge clk);
      rst = 1'b1;
      bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_funct3 = 3'b000; bus.req_addr = 64'd12;
      @(negedge clk);
      rst = 1'b0;
      bus.req_valid = 1'b0;
      checkOutput("rst priority req_ready", 64'(bus.req_ready), 64'd1);
      checkOutput("rst priority mem_read",  64'(bus.mem_read), 64'd0);

      // Store aborted by reset after three byte writes.
      s0 = respLog.size();
      w0 = writeAddrLog.size();
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = 3'b011;
      bus.req_addr = 64'd0; bus.req_wdata = 64'h1122334455667788;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("abort req_ready",  64'(bus.req_ready), 64'd1);
      checkOutput("abort mem_write",  64'(bus.mem_write), 64'd0);
      checkOutput("abort resp_valid", 64'(bus.resp_valid), 64'd0);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      checkOutput("abort resp count", 64'(respLog.size() - s0), 64'd0);
      checkOutput("abort write count", 64'(writeAddrLog.size() - w0), 64'd3);
      checkOutput("abort byte0", 64'(memArr[0]), 64'h88);
      checkOutput("abort byte1", 64'(memArr[1]), 64'h77);
      checkOutput("abort byte2", 64'(memArr[2]), 64'h66);
      for (int i = 3; i < 8; i++)
         checkOutput($sformatf("abort byte%0d", i), 64'(memArr[i]), 64'hFF);

      // Request held valid across a whole load: the next acceptance waits until the cycle after resp_valid.
      a0 = acceptLog.size();
      s0 = respLog.size();
      r0 = readAddrLog.size();
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_funct3 = 3'b000; bus.req_addr = 64'd12;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (acceptLog.size() - a0 >= 2) break;
      end
      bus.req_valid = 1'b0;
      repeat (6) @(negedge clk);
      checkOutput("b2b accept count", 64'(acceptLog.size() - a0), 64'd2);
      checkOutput("b2b read strobes", 64'(readAddrLog.size() - r0), 64'd2);
      checkOutput("b2b resp count", 64'(respLog.size() - s0), 64'd2);
      if (acceptLog.size() - a0 >= 2 && respLog.size() - s0 >= 1) begin
         checkOutput("b2b accept spacing", 64'(acceptLog[a0+1] - acceptLog[a0]), 64'd3);
         checkOutput("b2b accept after resp", 64'(acceptLog[a0+1] - respLog[s0]), 64'd1);
      end
      checkOutput("strobe overlap count", 64'(overlapCount), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/lsu_byte_seq.md
LSU_BYTE_SEQ -- requirements
Module: lsu_byte_seq

Interface
REQ-001 Parameter addr_size, default 64, is the width of all address ports.
REQ-002 Parameter data_length, default 64, is the width of the request and response data ports.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 req_valid  input  1  load/store request present.
REQ-006 req_ready  output  1  block can accept a request this cycle.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_funct3  input  3  RV64 funct3: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
REQ-009 req_addr  input  addr_size  byte address of the access.
REQ-010 req_wdata  input  data_length  store data; the low-order bytes are used.
REQ-011 resp_valid  output  1  one-cycle pulse marking request completion.
REQ-012 resp_rdata  output  data_length  extended load data; 0 for stores.
REQ-013 resp_err  output  1  misaligned-access flag, qualified by resp_valid.
REQ-014 mem_read, mem_write  output  1 each  byte-memory strobes, mutually exclusive.
REQ-015 mem_addr  output  addr_size  byte address sent to the data memory.
REQ-016 mem_wdata  output  8  store byte.
REQ-017 mem_rdata  input  8  load byte, valid combinationally in the same cycle mem_read is high.

Function
REQ-018 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-019 req_ready SHALL be 1 only in IDLE.
REQ-020 A request SHALL be accepted at a rising edge where req_valid and req_ready are both 1.
REQ-021 On acceptance the block SHALL latch the address, data, write flag and funct3, set N to 1, 2, 4 or 8 from funct3[1:0], clear the byte counter k, and enter ACCESS.
REQ-022 funct3[2] SHALL select zero-extension for loads and SHALL be ignored for stores and for the D size (so 111 behaves as LD).
REQ-023 In ACCESS the block SHALL drive mem_addr = base + k, computed modulo 2^addr_size so that it wraps around.
REQ-024 In ACCESS the block SHALL assert exactly one strobe: mem_read for loads, mem_write for stores.
REQ-025 For stores in ACCESS, mem_wdata SHALL be req_wdata[8k+7:8k], giving little-endian byte order.
REQ-026 For loads, each ACCESS edge SHALL capture mem_rdata into byte lane k of the assembly register.
REQ-027 Each ACCESS edge SHALL increment k; at the edge where k = N-1 the FSM SHALL enter RESP.
REQ-028 In RESP the block SHALL hold resp_valid = 1 for exactly one cycle, then return to IDLE.
REQ-029 resp_rdata SHALL be the assembled N bytes, sign- or zero-extended to data_length, and SHALL hold its value until the next RESP.
REQ-030 Latency SHALL be fixed: with the acceptance edge ending cycle 0, ACCESS occupies cycles 1..N, resp_valid is high in cycle N+1, and req_ready is high again in cycle N+2.
REQ-031 Outside ACCESS, mem_read, mem_write and mem_wdata SHALL be 0; mem_addr is don't-care.
REQ-032 req_valid asserted while req_ready = 0 SHALL be ignored and SHALL NOT be queued.

Reset
REQ-033 When rst is 1 at an edge, the block SHALL enter IDLE and clear k.
REQ-034 After that edge, outputs SHALL be: req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, mem_read = 0, mem_write = 0, mem_wdata = 0.
REQ-035 rst SHALL take priority over an acceptance in the same cycle.
REQ-036 A reset during ACCESS SHALL abort the request without any resp_valid; bytes already written SHALL remain in memory.

Configuration
REQ-037 With macro LSU_MISALIGN_TRAP_EN defined, a request with req_addr mod N != 0 SHALL go from IDLE directly to RESP with no memory strobes, and respond with resp_err = 1 and resp_rdata = 0 in cycle 1.
REQ-038 With LSU_MISALIGN_TRAP_EN undefined, misaligned requests SHALL execute byte-serially like aligned ones, and resp_err SHALL be constant 0.

Verification
REQ-039 Memory preset to 0xFF everywhere except byte 12 = 0xAA; LB addr 12 -> resp_valid in cycle 2 with rdata 0xFFFFFFFFFFFFFFAA; LBU addr 12 -> 0x00000000000000AA.
REQ-040 SD addr 16, wdata 0x0123456789ABCDEF -> 8 mem_write cycles with bytes EF, CD, AB, 89, 67, 45, 23, 01 at addresses 16..23 and resp_valid in cycle 9. Then LD 16 -> 0x0123456789ABCDEF, LW 16 -> 0xFFFFFFFF89ABCDEF, LHU 20 -> 0x0000000000004567.
REQ-041 LW addr 0xFFFFFFFFFFFFFFFE -> mem_addr sequence ...FE, ...FF, 0x0, 0x1 (wrap-around), tested with LSU_MISALIGN_TRAP_EN undefined.
REQ-042 LW addr 13 with LSU_MISALIGN_TRAP_EN defined -> no mem_read, resp_err = 1, rdata 0 in cycle 1. With the macro undefined -> rdata 0xFFFFFFFFFFFFFFFF, resp_err = 0.
REQ-043 SD addr 0, wdata 0x1122334455667788, rst asserted in ACCESS after 3 byte writes -> bytes 0..2 = 88, 77, 66, bytes 3..7 = FF, resp_valid never asserted, req_ready = 1 after the reset edge.
REQ-044 req_valid held high continuously during a load -> the second request is accepted only in the cycle after resp_valid, and no strobe overlaps between the two requests.
